// File: rtl/accum_pkg.sv
// accum_pkg: shared defaults and op-kind encoding for the accumulator bank
package accum_pkg;
  localparam int ACCUM_IN_W = 4;
  localparam int ACCUM_ACC_W = 16;
  localparam int ACCUM_NUM_CH = 4;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_LOAD} op_t;
endpackage

// File: rtl/accum_bank_if.sv
// accum_bank_if: request, read-port and result signals of the accumulator bank
interface accum_bank_if import accum_pkg::*; #(
  parameter int IN_W = ACCUM_IN_W,
  parameter int ACC_W = ACCUM_ACC_W,
  parameter int NUM_CH = ACCUM_NUM_CH
) ();
  localparam int CH_W = $clog2(NUM_CH);
  logic in_valid;
  logic load;
  logic [CH_W-1:0] in_ch;
  logic [IN_W-1:0] in_data;
  logic [ACC_W-1:0] load_data;
  logic clr_ovf;
  logic [CH_W-1:0] rd_ch;
  logic [ACC_W-1:0] rd_data;
  logic out_valid;
  logic [CH_W-1:0] out_ch;
  logic [ACC_W-1:0] out_data;
  logic [NUM_CH-1:0] ovf;
  modport master (
    output in_valid, load, in_ch, in_data, load_data, clr_ovf, rd_ch,
    input rd_data, out_valid, out_ch, out_data, ovf
  );
  modport slave (
    input in_valid, load, in_ch, in_data, load_data, clr_ovf, rd_ch,
    output rd_data, out_valid, out_ch, out_data, ovf
  );
endinterface

// File: rtl/accum_lane.sv
// accum_lane: one channel register with carry-out adder and sticky overflow (ACCUM_SAT_EN saturates on carry)
module accum_lane import accum_pkg::*; #(
  parameter int IN_W = ACCUM_IN_W,
  parameter int ACC_W = ACCUM_ACC_W
) (
  input  logic clk,
  input  logic Rst,
  input  logic add_en,
  input  logic load_en,
  input  logic clr,
  input  logic [IN_W-1:0] in_data,
  input  logic [ACC_W-1:0] load_data,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] nxt,
  output logic ovf
);
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] add_v;
  always_comb begin
    sum = {1'b0, acc} + (ACC_W+1)'(in_data);
`ifdef ACCUM_SAT_EN
    add_v = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    add_v = sum[ACC_W-1:0];
`endif
    nxt = load_en ? load_data : add_en ? add_v : acc;
  end
  // a carry in the same cycle as clr keeps the flag set
  always_ff @(posedge clk)
    if (Rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= nxt;
      ovf <= load_en ? 1'b0 : (add_en && sum[ACC_W]) ? 1'b1 : clr ? 1'b0 : ovf;
    end
endmodule

// File: rtl/accum_bank.sv
// accum_bank: NUM_CH-channel accumulator bank with registered result strobe (ACCUM_SAT_EN selects saturating adds)
module accum_bank import accum_pkg::*; #(
  parameter int IN_W = ACCUM_IN_W,
  parameter int ACC_W = ACCUM_ACC_W,
  parameter int NUM_CH = ACCUM_NUM_CH
) (
  input logic clk,
  input logic Rst,
  accum_bank_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] nxt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  op_t op;
  always_comb op = (32'(bus.in_ch) >= NUM_CH) ? OP_NONE : bus.load ? OP_LOAD : bus.in_valid ? OP_ADD : OP_NONE;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .Rst(Rst),
      .add_en(op == OP_ADD && bus.in_ch == CH_W'(c)),
      .load_en(op == OP_LOAD && bus.in_ch == CH_W'(c)),
      .clr(bus.clr_ovf),
      .in_data(bus.in_data),
      .load_data(bus.load_data),
      .acc(acc[c]),
      .nxt(nxt[c]),
      .ovf(ovf[c])
    );
  end
  assign bus.rd_data = acc[bus.rd_ch];
  assign bus.ovf = ovf;
  always_ff @(posedge clk)
    if (Rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch <= '0;
      bus.out_data <= '0;
    end else begin
      bus.out_valid <= op != OP_NONE;
      if (op != OP_NONE) begin
        bus.out_ch <= bus.in_ch;
        bus.out_data <= nxt[bus.in_ch];
      end
    end
endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: directed self-checking bench for accum_bank (expectations follow ACCUM_SAT_EN)
module tb_accum_bank;
  import accum_pkg::*;
  logic clk = 1'b0;
  logic Rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] sb [4];
  logic [16:0] s;
  accum_bank_if #(.IN_W(4), .ACC_W(16), .NUM_CH(4)) bus ();
  accum_bank #(.IN_W(4), .ACC_W(16), .NUM_CH(4)) dut (.clk(clk), .Rst(Rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.load = 0; bus.clr_ovf = 0;
  endtask

  task automatic add(input logic [1:0] ch, input logic [3:0] d);
    bus.in_valid = 1; bus.load = 0; bus.in_ch = ch; bus.in_data = d;
  endtask

  task automatic ld(input logic [1:0] ch, input logic [15:0] v);
    bus.in_valid = 0; bus.load = 1; bus.in_ch = ch; bus.load_data = v;
  endtask

  task automatic rd_all(input string tag, input logic [15:0] e0, e1, e2, e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      bus.rd_ch = 2'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_data), 32'(e[i]));
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.load = 0; bus.in_ch = 0; bus.in_data = 0;
    bus.load_data = 0; bus.clr_ovf = 0; bus.rd_ch = 0;
    ld(2'd1, 16'h0777);
    step();
    step();
    Rst = 0;
    idle();
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_ch", 32'(bus.out_ch), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    rd_all("rst", 16'h0, 16'h0, 16'h0, 16'h0);

    add(2'd0, 4'hF);
    step();
    check("add1_valid", 32'(bus.out_valid), 1);
    check("add1_ch", 32'(bus.out_ch), 0);
    check("add1_data", 32'(bus.out_data), 32'h000F);
    step();
    check("add2_valid", 32'(bus.out_valid), 1);
    check("add2_data", 32'(bus.out_data), 32'h001E);
    step();
    check("add3_valid", 32'(bus.out_valid), 1);
    check("add3_ch", 32'(bus.out_ch), 0);
    check("add3_data", 32'(bus.out_data), 32'h002D);
    idle();
    step();
    check("idle_valid", 32'(bus.out_valid), 0);
    check("idle_hold_data", 32'(bus.out_data), 32'h002D);
    check("idle_hold_ch", 32'(bus.out_ch), 0);

    ld(2'd2, 16'hFFFE);
    step();
    check("ld2_data", 32'(bus.out_data), 32'hFFFE);
    check("ld2_ch", 32'(bus.out_ch), 2);
    add(2'd2, 4'h3);
    step();
`ifdef ACCUM_SAT_EN
    check("ovf2_data", 32'(bus.out_data), 32'hFFFF);
`else
    check("ovf2_data", 32'(bus.out_data), 32'h0001);
`endif
    check("ovf2_flags", 32'(bus.ovf), 32'b0100);

    bus.in_valid = 1; bus.load = 1; bus.in_ch = 2'd1; bus.load_data = 16'h1234; bus.in_data = 4'h5;
    step();
    check("both_data", 32'(bus.out_data), 32'h1234);
    check("both_ch", 32'(bus.out_ch), 1);
    idle();
    step();
    bus.rd_ch = 2'd1;
    #1;
    check("both_rd", 32'(bus.rd_data), 32'h1234);

    ld(2'd3, 16'hFFF8);
    step();
    add(2'd3, 4'hF);
    step();
    check("ovf3_flags", 32'(bus.ovf), 32'b1100);
`ifdef ACCUM_SAT_EN
    check("ovf3_data", 32'(bus.out_data), 32'hFFFF);
`else
    check("ovf3_data", 32'(bus.out_data), 32'h0007);
`endif
    ld(2'd3, 16'hFFFF);
    step();
    check("ld3_clears_ovf", 32'(bus.ovf), 32'b0100);
    add(2'd3, 4'h1);
    bus.clr_ovf = 1;
    step();
    check("clr_vs_set", 32'(bus.ovf), 32'b1000);
`ifdef ACCUM_SAT_EN
    check("clr_vs_set_data", 32'(bus.out_data), 32'hFFFF);
`else
    check("clr_vs_set_data", 32'(bus.out_data), 32'h0000);
`endif
    idle();
    bus.clr_ovf = 1;
    step();
    check("clr_alone", 32'(bus.ovf), 0);
    check("clr_alone_valid", 32'(bus.out_valid), 0);
    idle();

    sb[0] = 16'h002D; sb[1] = 16'h1234;
`ifdef ACCUM_SAT_EN
    sb[2] = 16'hFFFF; sb[3] = 16'hFFFF;
`else
    sb[2] = 16'h0001; sb[3] = 16'h0000;
`endif
    rd_all("pre_il", sb[0], sb[1], sb[2], sb[3]);
    for (int k = 0; k < 8; k++) begin
      add(2'(k % 4), 4'(k + 1));
      bus.rd_ch = 2'(k % 4);
      #1;
      check($sformatf("il%0d_rd_pre", k), 32'(bus.rd_data), 32'(sb[k % 4]));
      bus.rd_ch = 2'((k + 2) % 4);
      #1;
      check($sformatf("il%0d_rd_other", k), 32'(bus.rd_data), 32'(sb[(k + 2) % 4]));
      s = {1'b0, sb[k % 4]} + 17'(k + 1);
`ifdef ACCUM_SAT_EN
      sb[k % 4] = s[16] ? 16'hFFFF : s[15:0];
`else
      sb[k % 4] = s[15:0];
`endif
      step();
      check($sformatf("il%0d_data", k), 32'(bus.out_data), 32'(sb[k % 4]));
      check($sformatf("il%0d_ch", k), 32'(bus.out_ch), 32'(k % 4));
    end
    idle();
    rd_all("post_il", sb[0], sb[1], sb[2], sb[3]);
`ifdef ACCUM_SAT_EN
    check("il_ovf", 32'(bus.ovf), 32'b1100);
`else
    check("il_ovf", 32'(bus.ovf), 0);
    check("il_ch0_value", 32'(sb[0]), 32'h0033);
`endif

    ld(2'd1, 16'h0050);
    step();
    check("pre_rst_data", 32'(bus.out_data), 32'h0050);
    add(2'd1, 4'h1);
    Rst = 1;
    step();
    Rst = 0;
    idle();
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_data", 32'(bus.out_data), 0);
    check("mid_rst_ovf", 32'(bus.ovf), 0);
    rd_all("mid_rst", 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    check("post_rst_idle", 32'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
